// File: rtl/nes_reset_sequencer.sv
// Boot/reset scheduler: gates the VGA and system resets on PLL lock, boot-load completion and game changes.
// Define NES_RSTSEQ_BOOTCOUNT_EN to count completed boots on boot_count (tied to zero otherwise).
module nes_reset_sequencer #(
  parameter int unsigned LOCK_FILTER  = 16,
  parameter int unsigned HOLD_CYCLES  = 64,
  parameter int unsigned LOAD_TIMEOUT = 1048576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       loading,
  input  logic       game_req,
  input  logic [3:0] game_sel,
  output logic [3:0] game,
  output logic       vga_rst_n,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       load_err,
  output logic [2:0] state,
  output logic [7:0] boot_count
);

  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_LOCK_FILT = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_WAIT_LOAD = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  localparam int LF_W = $clog2(LOCK_FILTER) + 1;
  localparam int HC_W = $clog2(HOLD_CYCLES) + 1;
  localparam int LT_W = $clog2(LOAD_TIMEOUT) + 1;

  localparam logic [LF_W-1:0] LF_LAST = LF_W'(LOCK_FILTER - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [LT_W-1:0] LT_LAST = LT_W'(LOAD_TIMEOUT - 1);

  logic [1:0]      lock_sync_q;
  logic [1:0]      load_sync_q;
  logic [2:0]      req_sync_q;
  logic            lock_s;
  logic            loading_s;
  logic            req_pulse;

  logic [2:0]      state_q, state_d;
  logic [LF_W-1:0] filt_q, filt_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic [LT_W-1:0] load_q, load_d;
  logic            pend_q, pend_d;
  logic [3:0]      game_q, game_d;
  logic            err_q, err_d;
  logic            vga_q, vga_d;
  logic            sys_q, sys_d;
  logic            ready_q, ready_d;
  logic            load_min;
  logic            load_tmo;

  assign lock_s    = lock_sync_q[1];
  assign loading_s = load_sync_q[1];
  // Third req stage only serves the edge detector; game_sel is sampled raw since it is held stable around the rise.
  assign req_pulse = req_sync_q[1] & ~req_sync_q[2];

  assign load_min = (load_q != '0);
  assign load_tmo = (load_q == LT_LAST);

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    load_d  = load_q;
    pend_d  = pend_q;
    game_d  = game_q;
    err_d   = err_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_LOCK_FILT;
          filt_d  = '0;
        end
      end
      ST_LOCK_FILT: begin
        if (filt_q == LF_LAST) begin
          state_d = ST_HOLD;
          hold_d  = '0;
          game_d  = game_sel;
        end else begin
          filt_d = filt_q + LF_W'(1);
        end
      end
      ST_HOLD: begin
        if (req_pulse) begin
          hold_d = '0;
          game_d = game_sel;
        end else if (hold_q == HC_LAST) begin
          state_d = ST_WAIT_LOAD;
          load_d  = '0;
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      ST_WAIT_LOAD: begin
        if (req_pulse) pend_d = 1'b1;
        if ((load_min && !loading_s) || load_tmo) begin
          if (load_tmo && loading_s) err_d = 1'b1;
          if (pend_q || req_pulse) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            game_d  = game_sel;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          load_d = load_q + LT_W'(1);
        end
      end
      ST_RUN: begin
        if (req_pulse) begin
          state_d = ST_HOLD;
          hold_d  = '0;
          game_d  = game_sel;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    // Lock loss wins over every other transition so sys_rst_n can never rise on a lock drop.
    if (!lock_s && (state_q != ST_WAIT_LOCK)) begin
      state_d = ST_WAIT_LOCK;
      filt_d  = '0;
      hold_d  = '0;
      load_d  = '0;
      pend_d  = 1'b0;
      game_d  = game_q;
      err_d   = err_q;
    end
  end

  assign vga_d   = (state_d == ST_WAIT_LOAD) || (state_d == ST_RUN);
  assign sys_d   = (state_d == ST_RUN);
  assign ready_d = (state_d == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= '0;
      load_sync_q <= '0;
      req_sync_q  <= '0;
      state_q     <= ST_WAIT_LOCK;
      filt_q      <= '0;
      hold_q      <= '0;
      load_q      <= '0;
      pend_q      <= 1'b0;
      game_q      <= '0;
      err_q       <= 1'b0;
      vga_q       <= 1'b0;
      sys_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked};
      load_sync_q <= {load_sync_q[0], loading};
      req_sync_q  <= {req_sync_q[1:0], game_req};
      state_q     <= state_d;
      filt_q      <= filt_d;
      hold_q      <= hold_d;
      load_q      <= load_d;
      pend_q      <= pend_d;
      game_q      <= game_d;
      err_q       <= err_d;
      vga_q       <= vga_d;
      sys_q       <= sys_d;
      ready_q     <= ready_d;
    end
  end

`ifdef NES_RSTSEQ_BOOTCOUNT_EN
  logic [7:0] boot_q, boot_d;

  always_comb begin
    boot_d = boot_q;
    if ((state_q == ST_WAIT_LOAD) && (state_d == ST_RUN) && (boot_q != 8'hFF))
      boot_d = boot_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) boot_q <= 8'h00;
    else        boot_q <= boot_d;
  end

  assign boot_count = boot_q;
`else
  assign boot_count = 8'h00;
`endif

  assign game      = game_q;
  assign vga_rst_n = vga_q;
  assign sys_rst_n = sys_q;
  assign ready     = ready_q;
  assign load_err  = err_q;
  assign state     = state_q;

endmodule
